// File: rtl/mux_2x1_pkg.sv
// mux_2x1_pkg: shared width default and select encodings for the 2:1 selector
package mux_2x1_pkg;
    localparam int MUX_WIDTH_DEF = 1;
    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;
endpackage

// File: rtl/mux_2x1_if.sv
// mux_2x1_if: operand, select, capture-enable and result bundle of the 2:1 selector
interface mux_2x1_if
    import mux_2x1_pkg::*;
#(
    parameter int WIDTH = MUX_WIDTH_DEF
);
    logic             en;
    logic             sel;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] y;
    logic [WIDTH-1:0] y_q;
    logic             y_q_valid;
    logic             sel_q;
    modport master (output en, sel, a, b, input y, y_q, y_q_valid, sel_q);
    modport slave (input en, sel, a, b, output y, y_q, y_q_valid, sel_q);
endinterface

// File: rtl/mux_2x1_core.sv
// mux_2x1_core: combinational WIDTH-bit 2:1 selector
module mux_2x1_core
    import mux_2x1_pkg::*;
#(
    parameter int WIDTH = MUX_WIDTH_DEF
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sel,
    output logic [WIDTH-1:0] y
);
    always_comb y = (sel == SEL_B) ? b : a;
endmodule

// File: rtl/mux_2x1.sv
// mux_2x1: 2:1 selector with zero-latency output and an enable-gated registered copy
module mux_2x1
    import mux_2x1_pkg::*;
#(
    parameter int WIDTH = MUX_WIDTH_DEF
) (
    input  logic       clk,
    input  logic       rst,
    mux_2x1_if.slave   bus
);
    logic [WIDTH-1:0] y;
    mux_2x1_core #(.WIDTH(WIDTH)) u_core (
        .a   (bus.a),
        .b   (bus.b),
        .sel (bus.sel),
        .y   (y)
    );
    assign bus.y = y;
    // valid tracks en so it is high exactly for the cycle after each capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.y_q       <= '0;
            bus.sel_q     <= SEL_A;
            bus.y_q_valid <= 1'b0;
        end else begin
            bus.y_q_valid <= bus.en;
            if (bus.en) begin
                bus.y_q   <= y;
                bus.sel_q <= bus.sel;
            end
        end
    end
endmodule

// File: tb/tb_mux_2x1.sv
// tb_mux_2x1: directed and random checks of the 2:1 selector, 1-bit and 8-bit instances
module tb_mux_2x1;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int total = 0;
    int bad = 0;
    logic [7:0] exp_q[$];
    logic [7:0] mq;
    logic ms, mv;
    mux_2x1_if #(.WIDTH(8)) bus8 ();
    mux_2x1_if #(.WIDTH(1)) bus1 ();
    mux_2x1 #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8.slave));
    mux_2x1 #(.WIDTH(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic pop_check(input string tag, input logic [7:0] obs);
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $error("FAIL %s observed=%h expected=<empty scoreboard>", tag, obs);
        end else check(tag, obs, exp_q.pop_front());
    endtask

    initial begin
        logic [2:0] tt [6];
        logic [7:0] ya;
        tt = '{3'b000, 3'b010, 3'b101, 3'b111, 3'b011, 3'b100};
        bus1.en = 1'b0; bus1.a = 1'b0; bus1.b = 1'b0; bus1.sel = 1'b0;
        bus8.en = 1'b0; bus8.a = 8'h00; bus8.b = 8'h00; bus8.sel = 1'b0;
        #2;
        check("reset_y_q", bus8.y_q, 8'h00);
        check("reset_sel_q", {7'd0, bus8.sel_q}, 8'h00);
        check("reset_valid", {7'd0, bus8.y_q_valid}, 8'h00);
        for (int i = 0; i < 6; i++) begin
            {bus1.a, bus1.b, bus1.sel} = tt[i];
            exp_q.push_back({7'd0, tt[i][0] ? tt[i][1] : tt[i][2]});
            #10;
            pop_check("truth_table_y", {7'd0, bus1.y});
        end
        bus8.a = 8'hA5; bus8.b = 8'h3C;
        for (int i = 0; i < 6; i++) begin
            bus8.sel = i[0];
            exp_q.push_back(i[0] ? 8'h3C : 8'hA5);
            #10;
            pop_check("wide_y", bus8.y);
        end
        @(negedge clk);
        rst = 1'b0; bus8.en = 1'b1; bus8.a = 8'h11; bus8.b = 8'h22; bus8.sel = 1'b1;
        exp_q.push_back(8'h22);
        @(posedge clk); #1;
        pop_check("capture_y_q", bus8.y_q);
        check("capture_sel_q", {7'd0, bus8.sel_q}, 8'h01);
        check("capture_valid", {7'd0, bus8.y_q_valid}, 8'h01);
        @(negedge clk);
        bus8.en = 1'b0; bus8.a = 8'h33; bus8.b = 8'h44; bus8.sel = 1'b0;
        @(posedge clk); #1;
        check("hold_y_q", bus8.y_q, 8'h22);
        check("hold_sel_q", {7'd0, bus8.sel_q}, 8'h01);
        check("hold_valid", {7'd0, bus8.y_q_valid}, 8'h00);
        @(negedge clk);
        bus8.en = 1'b1; bus8.a = 8'h11; bus8.b = 8'h22; bus8.sel = 1'b1;
        @(posedge clk); #1;
        check("recap_valid", {7'd0, bus8.y_q_valid}, 8'h01);
        @(negedge clk); #2;
        rst = 1'b1;
        #1;
        check("async_y_q", bus8.y_q, 8'h00);
        check("async_sel_q", {7'd0, bus8.sel_q}, 8'h00);
        check("async_valid", {7'd0, bus8.y_q_valid}, 8'h00);
        check("async_y", bus8.y, 8'h22);
        bus8.sel = 1'b0; #1;
        check("async_y_sel0", bus8.y, 8'h11);
        @(negedge clk);
        bus8.en = 1'b1; bus8.a = 8'hFF; bus8.sel = 1'b0;
        @(posedge clk); #1;
        check("in_reset_y_q", bus8.y_q, 8'h00);
        check("in_reset_valid", {7'd0, bus8.y_q_valid}, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        exp_q.push_back(8'hFF);
        @(posedge clk); #1;
        pop_check("release_y_q", bus8.y_q);
        check("release_valid", {7'd0, bus8.y_q_valid}, 8'h01);
        check("release_sel_q", {7'd0, bus8.sel_q}, 8'h00);
        mq = 8'hFF; ms = 1'b0; mv = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            bus8.a = 8'($urandom); bus8.b = 8'($urandom);
            bus8.sel = 1'($urandom); bus8.en = 1'($urandom);
            ya = bus8.sel ? bus8.b : bus8.a;
            exp_q.push_back(ya);
            #1;
            pop_check("rand_y", bus8.y);
            if (bus8.en) begin
                mq = ya; ms = bus8.sel;
            end
            mv = bus8.en;
            exp_q.push_back(mq);
            @(posedge clk); #1;
            pop_check("rand_y_q", bus8.y_q);
            check("rand_sel_q", {7'd0, bus8.sel_q}, {7'd0, ms});
            check("rand_valid", {7'd0, bus8.y_q_valid}, {7'd0, mv});
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
